// File: rtl/runway_slot_arbiter_pkg.sv
// runway_slot_arbiter_pkg: arbiter FSM encodings and ECSU weather states shared with ECSU
package runway_slot_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, GRANTED, CLEARING, LOCKED} arb_state_t;
  typedef enum logic [1:0] {ECSU_CLEAR, ECSU_CAUTION, ECSU_SEVERE, ECSU_EMERGENCY} ecsu_state_t;
endpackage

// File: rtl/runway_slot_arbiter_rr_picker.sv
// runway_slot_arbiter_rr_picker: first set bit of eff scanning ptr+1, ptr+2, ... modulo N
module runway_slot_arbiter_rr_picker
  import runway_slot_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int W = $clog2(N)
)(
  input  logic [N-1:0] eff,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] pick,
  output logic [W-1:0] idx,
  output logic         any
);
  logic [W-1:0] j;
  always_comb begin
    j = '0;
    idx = '0;
    any = 1'b0;
    for (int i = N; i >= 1; i--) begin
      j = W'((int'(ptr) + i) % N);
      if (eff[j]) begin
        idx = j;
        any = 1'b1;
      end
    end
  end
  assign pick = any ? N'(1) << idx : '0;
endmodule

// File: rtl/runway_slot_arbiter.sv
// runway_slot_arbiter: weather-gated round-robin runway grant with occupancy timeout and clearing interval
module runway_slot_arbiter
  import runway_slot_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int OCC_CYCLES = 8,
  parameter int CAUTION_EXTRA = 4,
  parameter int CLEAR_CYCLES = 2,
  localparam int W = $clog2(N_REQ)
)(
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_REQ-1:0] land_req,
  input  logic [N_REQ-1:0] emerg_req,
  input  logic [N_REQ-1:0] landed,
  input  logic [1:0]       ECSU_state,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic [W-1:0]     grant_id,
  output logic             runway_busy,
  output logic             timeout_err,
  output logic [1:0]       arb_state
);
  localparam logic [7:0] OCC_LD = 8'(OCC_CYCLES);
  localparam logic [7:0] CAU_LD = 8'(OCC_CYCLES + CAUTION_EXTRA);
  localparam logic [7:0] CLR_LD = 8'(CLEAR_CYCLES);
  arb_state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [W-1:0] ptr, ptr_n, id_n, idx;
  logic [N_REQ-1:0] grant_n, eff, pick;
  logic tout_n, any;
  assign eff = ECSU_state == ECSU_SEVERE ? '0 :
               ECSU_state == ECSU_EMERGENCY ? land_req & emerg_req : land_req;
  runway_slot_arbiter_rr_picker #(.N(N_REQ)) u_picker (
    .eff(eff), .ptr(ptr), .pick(pick), .idx(idx), .any(any)
  );
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= W'(N_REQ - 1);
      grant <= '0;
      grant_id <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ptr <= ptr_n;
      grant <= grant_n;
      grant_id <= id_n;
      timeout_err <= tout_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt != 8'd0 ? cnt - 8'd1 : 8'd0;
    ptr_n = ptr;
    grant_n = grant;
    id_n = grant_id;
    tout_n = 1'b0;
    case (state)
      IDLE:
        if (ECSU_state == ECSU_SEVERE) state_n = LOCKED;
        else if (any) begin
          state_n = GRANTED;
          grant_n = pick;
          id_n = idx;
          ptr_n = idx;
          cnt_n = ECSU_state == ECSU_CAUTION ? CAU_LD : OCC_LD;
        end
      GRANTED:
        if (landed[grant_id] || cnt <= 8'd1) begin
          tout_n = !landed[grant_id];
          state_n = CLEARING;
          grant_n = '0;
          cnt_n = CLR_LD;
        end
      CLEARING: state_n = cnt <= 8'd1 ? IDLE : CLEARING;
      LOCKED: state_n = ECSU_state != ECSU_SEVERE ? IDLE : LOCKED;
    endcase
  end
  assign grant_valid = |grant;
  assign runway_busy = state == GRANTED || state == CLEARING;
  assign arb_state = state;
endmodule

// File: tb/tb_runway_slot_arbiter.sv
// tb_runway_slot_arbiter: directed scenarios for runway_slot_arbiter with hand-computed expectations
module tb_runway_slot_arbiter;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic [3:0] land_req = '0, emerg_req = '0, landed = '0;
  logic [1:0] ECSU_state = 2'd0;
  logic [3:0] grant;
  logic grant_valid, runway_busy, timeout_err;
  logic [1:0] grant_id, arb_state;
  int pass_cnt = 0, total_cnt = 0;

  runway_slot_arbiter dut (
    .CLK(CLK), .RST(RST), .land_req(land_req), .emerg_req(emerg_req), .landed(landed),
    .ECSU_state(ECSU_state), .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id),
    .runway_busy(runway_busy), .timeout_err(timeout_err), .arb_state(arb_state)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic land_and_clear(input int id);
    landed = 4'(1 << id);
    step(1);
    landed = '0;
    step(2);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    step(1);
    RST = 1'b1;
  endtask

  task automatic test_reset();
    step(1);
    total_cnt++; if (grant !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", grant); else pass_cnt++;
    total_cnt++; if (grant_valid !== 1'b0) $display("FAIL reset_grant_valid: got %b want 0", grant_valid); else pass_cnt++;
    total_cnt++; if (grant_id !== 2'd0) $display("FAIL reset_grant_id: got %0d want 0", grant_id); else pass_cnt++;
    total_cnt++; if (runway_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", runway_busy); else pass_cnt++;
    total_cnt++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout_err); else pass_cnt++;
    total_cnt++; if (arb_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", arb_state); else pass_cnt++;
    RST = 1'b1;
  endtask

  task automatic test_basic();
    land_req = 4'b0101;
    step(1);
    total_cnt++; if (grant !== 4'b0001) $display("FAIL basic_grant0: got %b want 0001", grant); else pass_cnt++;
    total_cnt++; if (grant_valid !== 1'b1 || runway_busy !== 1'b1) $display("FAIL basic_valid_busy: got %b%b want 11", grant_valid, runway_busy); else pass_cnt++;
    total_cnt++; if (arb_state !== 2'd1) $display("FAIL basic_granted: got %0d want 1", arb_state); else pass_cnt++;
    step(2);
    landed = 4'b0001;
    step(1);
    landed = '0;
    total_cnt++; if (arb_state !== 2'd2 || grant !== 4'b0000) $display("FAIL basic_clear1: state %0d grant %b want 2 0000", arb_state, grant); else pass_cnt++;
    total_cnt++; if (timeout_err !== 1'b0) $display("FAIL basic_no_timeout: got %b want 0", timeout_err); else pass_cnt++;
    step(1);
    total_cnt++; if (arb_state !== 2'd2 || runway_busy !== 1'b1) $display("FAIL basic_clear2: state %0d busy %b want 2 1", arb_state, runway_busy); else pass_cnt++;
    step(1);
    total_cnt++; if (arb_state !== 2'd0 || grant !== 4'b0000) $display("FAIL basic_idle: state %0d grant %b want 0 0000", arb_state, grant); else pass_cnt++;
    step(1);
    land_req = '0;
    total_cnt++; if (grant !== 4'b0100 || grant_id !== 2'd2) $display("FAIL basic_grant2: grant %b id %0d want 0100 2", grant, grant_id); else pass_cnt++;
    land_and_clear(2);
  endtask

  task automatic test_timeout();
    land_req = 4'b0010;
    step(1);
    land_req = '0;
    total_cnt++; if (grant !== 4'b0010) $display("FAIL to_grant: got %b want 0010", grant); else pass_cnt++;
    for (int i = 1; i <= 7; i++) begin
      step(1);
      total_cnt++; if (timeout_err !== 1'b0 || grant !== 4'b0010) $display("FAIL to_hold%0d: timeout %b grant %b want 0 0010", i, timeout_err, grant); else pass_cnt++;
    end
    step(1);
    total_cnt++; if (timeout_err !== 1'b1 || arb_state !== 2'd2 || grant !== 4'b0000) $display("FAIL to_pulse8: timeout %b state %0d grant %b want 1 2 0000", timeout_err, arb_state, grant); else pass_cnt++;
    step(1);
    total_cnt++; if (timeout_err !== 1'b0 || arb_state !== 2'd2) $display("FAIL to_pulse_end: timeout %b state %0d want 0 2", timeout_err, arb_state); else pass_cnt++;
    step(1);
    ECSU_state = 2'd1;
    land_req = 4'b0010;
    step(1);
    ECSU_state = 2'd0;
    land_req = '0;
    total_cnt++; if (grant !== 4'b0010) $display("FAIL to_caution_grant: got %b want 0010", grant); else pass_cnt++;
    for (int i = 1; i <= 11; i++) begin
      step(1);
      total_cnt++; if (timeout_err !== 1'b0 || arb_state !== 2'd1) $display("FAIL to_caution_hold%0d: timeout %b state %0d want 0 1", i, timeout_err, arb_state); else pass_cnt++;
    end
    step(1);
    total_cnt++; if (timeout_err !== 1'b1 || arb_state !== 2'd2) $display("FAIL to_pulse12: timeout %b state %0d want 1 2", timeout_err, arb_state); else pass_cnt++;
    step(2);
  endtask

  task automatic test_locked();
    do_reset();
    ECSU_state = 2'd2;
    land_req = 4'b1111;
    step(1);
    total_cnt++; if (arb_state !== 2'd3 || grant !== 4'b0000) $display("FAIL lock_enter: state %0d grant %b want 3 0000", arb_state, grant); else pass_cnt++;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      total_cnt++; if (arb_state !== 2'd3 || grant !== 4'b0000 || runway_busy !== 1'b0) $display("FAIL lock_hold%0d: state %0d grant %b busy %b want 3 0000 0", i, arb_state, grant, runway_busy); else pass_cnt++;
    end
    ECSU_state = 2'd0;
    step(1);
    total_cnt++; if (arb_state !== 2'd0 || grant !== 4'b0000) $display("FAIL lock_exit: state %0d grant %b want 0 0000", arb_state, grant); else pass_cnt++;
    step(1);
    land_req = '0;
    total_cnt++; if (grant !== 4'b0001) $display("FAIL lock_then_grant: got %b want 0001", grant); else pass_cnt++;
    land_and_clear(0);
  endtask

  task automatic test_emergency();
    ECSU_state = 2'd3;
    land_req = 4'b1111;
    emerg_req = 4'b0100;
    step(1);
    total_cnt++; if (grant !== 4'b0100 || grant_id !== 2'd2) $display("FAIL emerg_grant: grant %b id %0d want 0100 2", grant, grant_id); else pass_cnt++;
    land_and_clear(2);
    emerg_req = '0;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      total_cnt++; if (grant !== 4'b0000 || arb_state !== 2'd0) $display("FAIL emerg_none%0d: grant %b state %0d want 0000 0", i, grant, arb_state); else pass_cnt++;
    end
    ECSU_state = 2'd0;
    land_req = '0;
  endtask

  task automatic test_corner();
    land_req = 4'b0010;
    step(1);
    land_req = '0;
    total_cnt++; if (grant !== 4'b0010) $display("FAIL corner_grant: got %b want 0010", grant); else pass_cnt++;
    landed = 4'b1000;
    step(1);
    landed = '0;
    total_cnt++; if (grant !== 4'b0010 || arb_state !== 2'd1) $display("FAIL corner_foreign_landed: grant %b state %0d want 0010 1", grant, arb_state); else pass_cnt++;
    ECSU_state = 2'd2;
    step(1);
    ECSU_state = 2'd0;
    total_cnt++; if (grant !== 4'b0010 || arb_state !== 2'd1) $display("FAIL corner_severe_hold: grant %b state %0d want 0010 1", grant, arb_state); else pass_cnt++;
    for (int i = 3; i <= 7; i++) begin
      step(1);
      total_cnt++; if (grant !== 4'b0010 || timeout_err !== 1'b0) $display("FAIL corner_hold%0d: grant %b timeout %b want 0010 0", i, grant, timeout_err); else pass_cnt++;
    end
    landed = 4'b0010;
    step(1);
    landed = '0;
    total_cnt++; if (timeout_err !== 1'b0 || arb_state !== 2'd2) $display("FAIL corner_landed_wins: timeout %b state %0d want 0 2", timeout_err, arb_state); else pass_cnt++;
    step(1);
    total_cnt++; if (timeout_err !== 1'b0) $display("FAIL corner_no_late_timeout: got %b want 0", timeout_err); else pass_cnt++;
    step(1);
  endtask

  task automatic test_async_reset();
    land_req = 4'b1010;
    step(1);
    total_cnt++; if (grant !== 4'b1000 || grant_id !== 2'd3) $display("FAIL areset_pre_grant: grant %b id %0d want 1000 3", grant, grant_id); else pass_cnt++;
    #2 RST = 1'b0;
    #1;
    total_cnt++; if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0) $display("FAIL areset_grant: grant %b valid %b id %0d want 0000 0 0", grant, grant_valid, grant_id); else pass_cnt++;
    total_cnt++; if (arb_state !== 2'd0 || runway_busy !== 1'b0 || timeout_err !== 1'b0) $display("FAIL areset_state: state %0d busy %b timeout %b want 0 0 0", arb_state, runway_busy, timeout_err); else pass_cnt++;
    step(1);
    RST = 1'b1;
    step(1);
    land_req = '0;
    total_cnt++; if (grant !== 4'b0010 || grant_id !== 2'd1) $display("FAIL areset_regrant: grant %b id %0d want 0010 1", grant, grant_id); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_locked();
    test_emergency();
    test_corner();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
